// File: rtl/cube.sv
`default_nettype none
// ============================================================================
// Module      : cube
// Description : Sequential 5-bit integer cuber, result = y^3. Two fixed
//               five-step shift-and-add passes (square, then cube) with every
//               addition done by an external combinational adder reached
//               through sum_in_a / sum_in_b / sum_out. The latency is always
//               10 cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module cube (
    input  wire logic        clk,
    input  wire logic        rst,
    input  wire logic        start,
    input  wire logic [4:0]  y_i,
    output logic      [15:0] result,
    output logic             busy,
    output logic      [15:0] sum_in_a,
    output logic      [15:0] sum_in_b,
    input  wire logic [15:0] sum_out
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SQ   = 2'd1,
        S_CB   = 2'd2
    } state_t;

    localparam logic [2:0] c_LAST_BIT = 3'd4;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [4:0]  r_y;
    logic [2:0]  r_i;
    logic [15:0] r_acc;
    logic [15:0] r_mcand;
    logic [15:0] r_result;
    logic        r_busy;
    logic        w_last;

    assign w_last = (r_i == c_LAST_BIT);
    assign result = r_result;
    assign busy   = r_busy;

    // Next-state selection and adder operand steering. The adder inputs are
    // held at zero whenever no pass is running.
    always_comb begin
        w_state_nxt = r_state;
        sum_in_a    = 16'd0;
        sum_in_b    = 16'd0;
        unique case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = S_SQ;
                end
            end
            S_SQ, S_CB: begin
                sum_in_a = r_acc;
                // Zero bits still take a step so the latency never varies.
                sum_in_b = r_y[r_i] ? (r_mcand << r_i) : 16'd0;
                if (w_last) begin
                    w_state_nxt = (r_state == S_SQ) ? S_CB : S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Datapath: operand capture, accumulate, pass hand-over and completion.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_y      <= 5'd0;
            r_i      <= 3'd0;
            r_acc    <= 16'd0;
            r_mcand  <= 16'd0;
            r_result <= 16'd0;
            r_busy   <= 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_y     <= y_i;
                        r_acc   <= 16'd0;
                        r_mcand <= {11'd0, y_i};
                        r_i     <= 3'd0;
                        r_busy  <= 1'b1;
                    end
                end
                S_SQ: begin
                    if (w_last) begin
                        // The square becomes the multiplicand of the cube pass.
                        r_mcand <= sum_out;
                        r_acc   <= 16'd0;
                        r_i     <= 3'd0;
                    end else begin
                        r_acc <= sum_out;
                        r_i   <= r_i + 3'd1;
                    end
                end
                S_CB: begin
                    if (w_last) begin
                        r_result <= sum_out;
                        r_acc    <= 16'd0;
                        r_i      <= 3'd0;
                        r_busy   <= 1'b0;
                    end else begin
                        r_acc <= sum_out;
                        r_i   <= r_i + 3'd1;
                    end
                end
                default: begin
                    r_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/cube.md
# cube

Sequential integer cuber: computes result = y_i³ for a 5-bit unsigned operand. It is the inverse companion of the cube-root engine and shares its conventions: start/busy handshake and all additions done by the external combinational `sum` block through the sum_in_a/sum_in_b/sum_out port trio. Squaring and cubing are done as two fixed-length shift-and-add passes, giving a constant 10-cycle latency.

## Interface
- No parameters; all widths fixed.
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request pulse; honoured only while busy=0.
- y_i  in  5  unsigned operand (0..31); sampled on the accepting edge only.
- result  out  16  y³ (max 29791); registered; holds until next completion.
- busy  out  1  high while a computation is in progress.
- sum_in_a  out  16  adder operand A.
- sum_in_b  out  16  adder operand B.
- sum_out  in  16  adder result (a+b mod 2^16), combinational from the external `sum` block.

## Operation
- States: IDLE, SQ, CB.
- Internal regs: y (5b latched operand), i (3b bit index 0..4), acc (16b), mcand (16b).
- IDLE: busy=0; sum_in_a=0, sum_in_b=0. On start=1: y←y_i, acc←0, mcand←{11'b0,y_i}, i←0, busy←1, go SQ.
- SQ step (one per cycle, i=0..4): sum_in_a=acc; sum_in_b = y[i] ? (mcand<<i) : 0; acc←sum_out; i←i+1. Steps always execute for every bit, including zero bits (fixed latency).
- After SQ step i=4: mcand←sum_out (= y², max 961), acc←0, i←0, go CB.
- CB step: identical datapath with mcand=y². mcand<<4 ≤ 15376, every partial sum ≤ 29791; no overflow is possible, no overflow flag.
- After CB step i=4: result←sum_out, busy←0, go IDLE.
- start while busy=1: ignored, no effect on y, acc, or timing.
- y_i changes while busy: ignored.
- start held high continuously: a new computation is accepted on the first edge in IDLE, i.e. the edge after busy falls is not required to wait; back-to-back operation is permitted (the IDLE cycle between runs is mandatory, one cycle minimum).
- Adder is used only in SQ/CB; outputs to it are 0 in IDLE.

## Timing
- Reset (rst=1 on an edge): state←IDLE, busy←0, result←0, acc←0, i←0, mcand←0; sum_in_a/sum_in_b=0. rst dominates start on the same edge.
- Reset mid-operation: computation aborted, result forced to 0, busy=0 after that edge.
- Accepting edge E (start=1, busy=0): busy=1 visible after E.
- SQ steps on edges E+1..E+5; CB steps on edges E+6..E+10.
- After edge E+10: result valid, busy=0. busy is high exactly 10 cycles.
- result changes only on completion edge or reset; stable during busy (shows previous value).
- Earliest next acceptance: edge E+11.

## Test plan
- Reset, then y_i=3, start 1 cycle -> busy high exactly 10 cycles, result=27; result reads 0 while busy.
- Sequential runs y_i=0,1,2,7 -> results 0,1,8,343, each with 10-cycle busy; result between runs holds previous value.
- y_i=31 (maximum) -> result=29791; monitor sum_in_a+sum_in_b never exceeds 16 bits.
- Start y_i=5; at cycle 3 of busy pulse start=1 with y_i=4 -> ignored; result=125 after 10 cycles total.
- Start y_i=6; assert rst at cycle 5 of busy -> busy=0, result=0 next cycle; then y_i=6 run -> 216.
- start held high for 25 cycles with y_i=2 -> two completions (result=8), busy low exactly one cycle between runs.
